// File: rtl/audio_codec_frame_master.sv
// ---------------------------------------------------------------------------
// audio_codec_frame_master
//
// Master-side end of a DSP/PCM Mode B audio link. It stands in for a codec on
// loopback boards and in system-level simulation of the audio unit.
//
// From one system clock it generates:
//   - the bit clock ac_bclk;
//   - the frame-sync strobes ac_pblrc and ac_reclrc, which are identical.
//
// Each frame is FRAME_BCLKS bit periods long:
//   - period 0 is the sync period;
//   - periods 1..W carry the left channel, MSB first;
//   - periods W+1..2W carry the right channel, MSB first;
//   - the remaining periods are idle.
//
// Ports:
//   clk, resetn       system clock, synchronous active-low reset
//   enable            1 runs the link, 0 holds it idle
//   word_length       00=16, 01=20, 10=24, 11=32 bits per channel
//   ac_bclk           bit clock
//   ac_pblrc          playback frame sync
//   ac_reclrc         record frame sync, same as ac_pblrc
//   ac_pbdat          playback serial data in
//   ac_recdat         record serial data out
//   pb_axis_*         AXI-Stream master carrying captured playback frames
//                     (left = [W-1:0], right = [32+W-1:32])
//   rec_axis_*        AXI-Stream slave supplying record words
//   overflow          1-clk pulse: a captured frame was dropped
//   underflow         1-clk pulse: no record word was available at frame start
//   loopback_sel      present only when AUDIO_LOOPBACK_EN is defined; selects
//                     the last captured playback word as the record word
//
// Optional feature macro: AUDIO_LOOPBACK_EN
// ---------------------------------------------------------------------------
module audio_codec_frame_master #(
  parameter int BCLK_DIV    = 4,
  parameter int FRAME_BCLKS = 80
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [1:0]  word_length,
`ifdef AUDIO_LOOPBACK_EN
  input  logic        loopback_sel,
`endif
  output logic        ac_bclk,
  output logic        ac_pblrc,
  output logic        ac_reclrc,
  input  logic        ac_pbdat,
  output logic        ac_recdat,
  output logic        pb_axis_tvalid,
  input  logic        pb_axis_tready,
  output logic [63:0] pb_axis_tdata,
  input  logic        rec_axis_tvalid,
  output logic        rec_axis_tready,
  input  logic [63:0] rec_axis_tdata,
  output logic        overflow,
  output logic        underflow
);

  generate
    if (BCLK_DIV < 2 || FRAME_BCLKS < 65) begin : g_param_check
      $error("audio_codec_frame_master: BCLK_DIV must be >= 2 and FRAME_BCLKS >= 65");
    end
  endgenerate

  localparam int DW = $clog2(BCLK_DIV);
  localparam int CW = $clog2(FRAME_BCLKS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BCLKS - 1);

  typedef enum logic {
    ST_WAIT_SYNC,
    ST_FRAME
  } link_state_t;

  link_state_t state_q, state_d;

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_nxt;
  logic [5:0]    w_len;
  logic [5:0]    w_new;
  logic [CW-1:0] w_ext;
  logic [CW-1:0] two_w;

  logic div_wrap, rise_tick, fall_tick, frame_start;
  logic frame_active, in_slot, in_left, last_slot, cap_done;
  logic nxt_slot, nxt_left;

  logic [31:0] cap_left, cap_right, right_next;
  logic [31:0] rec_left, rec_right;
  logic [63:0] rec_src;
  logic        rec_take, rec_miss;

`ifdef AUDIO_LOOPBACK_EN
  logic [63:0] last_cap;
`endif

  function automatic logic [5:0] decode_w(input logic [1:0] wl);
    case (wl)
      2'b00:   decode_w = 6'd16;
      2'b01:   decode_w = 6'd20;
      2'b10:   decode_w = 6'd24;
      default: decode_w = 6'd32;
    endcase
  endfunction

  // Timing decodes. Both ticks are gated by enable, so dropping enable stops
  // every frame-related action on the very next clk.
  assign div_wrap    = enable && (div_cnt == DIV_LAST);
  assign rise_tick   = div_wrap && !ac_bclk;
  assign fall_tick   = div_wrap && ac_bclk;
  assign frame_start = fall_tick && (bit_cnt == CNT_LAST);
  assign bit_cnt_nxt = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CW'(1);

  assign w_new = decode_w(word_length);
  assign w_ext = CW'(w_len);
  assign two_w = CW'({w_len, 1'b0});

  // bit_cnt powers up parked at FRAME_BCLKS-1. That count lands on a slot
  // number when FRAME_BCLKS is 65, so slots are only honoured once a real
  // sync period has been seen.
  assign frame_active = (state_q == ST_FRAME);
  assign in_slot      = frame_active && (bit_cnt != '0) && (bit_cnt <= two_w);
  assign in_left      = (bit_cnt <= w_ext);
  assign last_slot    = frame_active && (bit_cnt == two_w);
  assign cap_done     = rise_tick && last_slot;
  assign nxt_slot     = frame_active && (bit_cnt_nxt != '0) && (bit_cnt_nxt <= two_w);
  assign nxt_left     = (bit_cnt_nxt <= w_ext);

  // The last right-channel bit is sampled on the same edge that completes
  // the frame, so the outgoing word includes it combinationally.
  assign right_next = {cap_right[30:0], ac_pbdat};

  assign ac_reclrc = ac_pblrc;

  // The link state register tracks whether a sync period has been seen
  // since the link was last enabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a frame starts at the first sync period and is
  // abandoned whenever enable drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SYNC: if (frame_start) state_d = ST_FRAME;
      ST_FRAME:     if (!enable)     state_d = ST_WAIT_SYNC;
      default:      state_d = ST_WAIT_SYNC;
    endcase
  end

  // Choose the record word latched at frame start. In loopback mode the
  // captured playback word is used and the AXIS source is left untouched.
  always_comb begin
    rec_take = 1'b0;
    rec_miss = 1'b0;
    rec_src  = '0;
`ifdef AUDIO_LOOPBACK_EN
    if (loopback_sel) begin
      rec_src = last_cap;
    end else if (rec_axis_tvalid) begin
`else
    if (rec_axis_tvalid) begin
`endif
      rec_take = 1'b1;
      rec_src  = rec_axis_tdata;
    end else begin
      rec_miss = 1'b1;
    end
  end

  assign rec_axis_tready = resetn && frame_start && rec_take;

  // This block handles:
  //   - the bit-clock divider and the frame counter;
  //   - the serial shift registers for both directions.
  // Record channels are MSB-aligned at load time, so each slot simply emits
  // bit 31 and shifts left.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt   <= '0;
      ac_bclk   <= 1'b0;
      bit_cnt   <= CNT_LAST;
      ac_pblrc  <= 1'b0;
      ac_recdat <= 1'b0;
      w_len     <= 6'd16;
      cap_left  <= '0;
      cap_right <= '0;
      rec_left  <= '0;
      rec_right <= '0;
    end else if (!enable) begin
      div_cnt   <= '0;
      ac_bclk   <= 1'b0;
      bit_cnt   <= CNT_LAST;
      ac_pblrc  <= 1'b0;
      ac_recdat <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
      if (div_wrap) begin
        ac_bclk <= ~ac_bclk;
      end

      if (fall_tick) begin
        bit_cnt  <= bit_cnt_nxt;
        ac_pblrc <= frame_start;
        if (frame_start) begin
          w_len     <= w_new;
          cap_left  <= '0;
          cap_right <= '0;
          rec_left  <= rec_src[31:0]  << (6'd32 - w_new);
          rec_right <= rec_src[63:32] << (6'd32 - w_new);
          ac_recdat <= 1'b0;
        end else if (nxt_slot) begin
          if (nxt_left) begin
            ac_recdat <= rec_left[31];
            rec_left  <= {rec_left[30:0], 1'b0};
          end else begin
            ac_recdat <= rec_right[31];
            rec_right <= {rec_right[30:0], 1'b0};
          end
        end else begin
          ac_recdat <= 1'b0;
        end
      end

      if (rise_tick && in_slot) begin
        if (in_left) begin
          cap_left <= {cap_left[30:0], ac_pbdat};
        end else begin
          cap_right <= right_next;
        end
      end
    end
  end

  // Playback AXIS output:
  //   - a completed frame loads whenever the output register is free, or is
  //     being accepted in the same clk;
  //   - otherwise the new frame is dropped and flagged as overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pb_axis_tvalid <= 1'b0;
      pb_axis_tdata  <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= frame_start && rec_miss;
      if (cap_done) begin
        if (!pb_axis_tvalid || pb_axis_tready) begin
          pb_axis_tdata  <= {right_next, cap_left};
          pb_axis_tvalid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (pb_axis_tvalid && pb_axis_tready) begin
        pb_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef AUDIO_LOOPBACK_EN
  // The loopback source is the newest captured frame, whether or not the
  // downstream sink has accepted it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_cap <= '0;
    end else if (cap_done) begin
      last_cap <= {right_next, cap_left};
    end
  end
`endif

endmodule
